// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command-driven sequencer for a bank of WIDTH JK flops.
// Accepts one command at a time (valid/ready) and drives per-bit J/K to set,
// clear, toggle, load, or count the bank up/down by a programmed step count.
// All outputs come straight from flops; their next values are decoded from
// the next state, next latched fields and next bank value.
module jk_bank_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,        // asynchronous, active-low
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [WIDTH-1:0] j_out,
   output logic [WIDTH-1:0] k_out,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_SET  = 3'd1;
   localparam logic [2:0] OP_CLR  = 3'd2;
   localparam logic [2:0] OP_TOG  = 3'd3;
   localparam logic [2:0] OP_LOAD = 3'd4;
   localparam logic [2:0] OP_UP   = 3'd5;
   localparam logic [2:0] OP_DN   = 3'd6;
   localparam logic [2:0] OP_RSV  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] j_out_q, j_out_d;
   logic [WIDTH-1:0] k_out_q, k_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cmd_ready_q, cmd_ready_d;

   // Toggle masks for a binary up/down count step, evaluated on the value the
   // bank will hold during the step (q_d), since j/k are registered.
   logic [WIDTH-1:0] up_mask;
   logic [WIDTH-1:0] dn_mask;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_mask
         if (gi == 0) begin : g_lsb
            assign up_mask[gi] = 1'b1;
            assign dn_mask[gi] = 1'b1;
         end else begin : g_upper
            assign up_mask[gi] = &q_d[gi-1:0];
            assign dn_mask[gi] = ~(|q_d[gi-1:0]);
         end
      end
   endgenerate

   // JK bank law applied with the drive presented this cycle.
   always_comb begin
      q_d = (j_out_q & ~q_q) | (~k_out_q & q_q);
   end

   // Next-state logic: command acceptance, field latching, step counter.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d   = cmd_op;
               data_d = cmd_data;
               cnt_d  = cmd_count;
               if (cmd_op == OP_UP || cmd_op == OP_DN) begin
                  // A zero-length count completes without touching the bank.
                  state_d = (cmd_count != '0) ? ST_COUNT : ST_DONE;
               end else begin
                  state_d = ST_APPLY;
               end
            end
         end
         ST_APPLY: begin
            state_d = ST_DONE;
         end
         ST_COUNT: begin
            cnt_d = cnt_q - CNT_W'(1);
            // This step is the last one when the counter hits zero here.
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from next-cycle state and fields, so outputs are flops.
   always_comb begin
      j_out_d     = '0;
      k_out_d     = '0;
      done_d      = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
      cmd_ready_d = (state_d == ST_IDLE);
      case (state_d)
         ST_APPLY: begin
            case (op_d)
               OP_SET: begin
                  j_out_d = data_d;
               end
               OP_CLR: begin
                  k_out_d = data_d;
               end
               OP_TOG: begin
                  j_out_d = data_d;
                  k_out_d = data_d;
               end
               OP_LOAD: begin
                  j_out_d = data_d;
                  k_out_d = ~data_d;
               end
               OP_NOP, OP_RSV: begin
                  j_out_d = '0;
                  k_out_d = '0;
               end
               default: begin
                  j_out_d = '0;
                  k_out_d = '0;
               end
            endcase
         end
         ST_COUNT: begin
            if (op_d == OP_UP) begin
               j_out_d = up_mask;
               k_out_d = up_mask;
            end else begin
               j_out_d = dn_mask;
               k_out_d = dn_mask;
            end
         end
         default: begin
            j_out_d = '0;
            k_out_d = '0;
         end
      endcase
   end

   // State, latched command fields, bank and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         data_q      <= '0;
         cnt_q       <= '0;
         q_q         <= '0;
         j_out_q     <= '0;
         k_out_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         q_q         <= q_d;
         j_out_q     <= j_out_d;
         k_out_q     <= k_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cmd_ready_q <= cmd_ready_d;
      end
   end

   assign q         = q_q;
   assign j_out     = j_out_q;
   assign k_out     = k_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed testbench for jk_bank_sequencer (WIDTH=4, CNT_W=8).
module tb_jk_bank_sequencer;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_data;
   logic [7:0] cmd_count;
   logic [3:0] j_out;
   logic [3:0] k_out;
   logic [3:0] q;
   logic       busy;
   logic       done;

   int err_cnt;
   int chk_cnt;

   jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .j_out     (j_out),
      .k_out     (k_out),
      .q         (q),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check, reports any mismatch.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present a command at a negedge, let it be taken at the next posedge.
   task automatic issue(input logic [2:0] op, input logic [3:0] data, input logic [7:0] cnt);
      @(negedge clk);
      check("ready_before_issue", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = cnt;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = 4'h0;
      cmd_count = 8'd0;
   endtask

   // Single-step command: APPLY cycle, DONE cycle, then IDLE.
   task automatic do_single(input string tag, input logic [2:0] op, input logic [3:0] data,
                            input logic [3:0] exp_j, input logic [3:0] exp_k, input logic [3:0] exp_q);
      issue(op, data, 8'd0);
      @(negedge clk);
      check({tag, "_apply_j"}, {28'd0, j_out}, {28'd0, exp_j});
      check({tag, "_apply_k"}, {28'd0, k_out}, {28'd0, exp_k});
      check({tag, "_apply_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_apply_done"}, {31'd0, done}, 32'd0);
      @(negedge clk);
      check({tag, "_q"}, {28'd0, q}, {28'd0, exp_q});
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_done_jk"}, {24'd0, j_out, k_out}, 32'd0);
      @(negedge clk);
      check({tag, "_idle_ready"}, {31'd0, cmd_ready}, 32'd1);
      check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      $display("txn %s op=%0d data=%b q=%b", tag, op, data, q);
   endtask

   // Count command: seq holds the expected q after each step (nibble k = step k+1).
   task automatic do_count(input string tag, input logic [2:0] op, input int n,
                           input logic [3:0] first_mask, input logic [3:0] start_q,
                           input logic [31:0] seq);
      issue(op, 4'h0, n[7:0]);
      @(negedge clk);
      if (n == 0) begin
         check({tag, "_done"}, {31'd0, done}, 32'd1);
         check({tag, "_jk"}, {24'd0, j_out, k_out}, 32'd0);
         check({tag, "_q_hold"}, {28'd0, q}, {28'd0, start_q});
      end else begin
         check({tag, "_first_j"}, {28'd0, j_out}, {28'd0, first_mask});
         check({tag, "_first_k"}, {28'd0, k_out}, {28'd0, first_mask});
         check({tag, "_first_busy"}, {31'd0, busy}, 32'd1);
         for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check({tag, "_step_q"}, {28'd0, q}, {28'd0, seq[4*(k-1) +: 4]});
            check({tag, "_step_done"}, {31'd0, done}, {31'd0, (k == n)});
            check({tag, "_step_busy"}, {31'd0, busy}, 32'd1);
         end
      end
      @(negedge clk);
      check({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_end_ready"}, {31'd0, cmd_ready}, 32'd1);
      check({tag, "_end_done"}, {31'd0, done}, 32'd0);
      check({tag, "_end_jk"}, {24'd0, j_out, k_out}, 32'd0);
      $display("txn %s op=%0d count=%0d q=%h", tag, op, n, q);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int done_seen;
      int acc_seen;
      logic [3:0] exp_q;
      err_cnt   = 0;
      chk_cnt   = 0;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = 4'h0;
      cmd_count = 8'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_q", {28'd0, q}, 32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_jk", {24'd0, j_out, k_out}, 32'd0);
      rst = 1'b1;
      $display("txn reset released q=%b", q);

      // Bit-mask commands
      do_single("set",  3'd1, 4'b1010, 4'b1010, 4'b0000, 4'b1010);
      do_single("clr",  3'd2, 4'b1000, 4'b0000, 4'b1000, 4'b0010);
      do_single("tog",  3'd3, 4'b0110, 4'b0110, 4'b0110, 4'b0100);
      do_single("tog2", 3'd3, 4'b0010, 4'b0010, 4'b0010, 4'b0110);
      do_single("load", 3'd4, 4'b1101, 4'b1101, 4'b0010, 4'b1101);

      // Count up 5 from D: E,F,0,1,2 (nibble 0 = first step)
      do_count("up5", 3'd5, 5, 4'b0011, 4'hD, 32'h0002_10FE);

      // NOP and reserved leave the bank alone
      do_single("nop", 3'd0, 4'hF, 4'h0, 4'h0, 4'h2);
      do_single("rsv", 3'd7, 4'hF, 4'h0, 4'h0, 4'h2);

      // Zero-length count, then count down 3 from 2 wrapping through 0: 1,0,F
      do_count("dn0", 3'd6, 0, 4'h0, 4'h2, 32'h0);
      do_count("dn3", 3'd6, 3, 4'b0011, 4'h2, 32'h0000_0F01);

      // Back-to-back: cmd_valid held high with TOG 0001, q starts at F
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd3;
      cmd_data  = 4'b0001;
      done_seen = 0;
      acc_seen  = 0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         exp_q = 4'hF ^ {3'b000, ((i >= 2) ^ (i >= 5) ^ (i >= 8))};
         check("b2b_ready", {31'd0, cmd_ready}, {31'd0, (i % 3 == 0)});
         check("b2b_q", {28'd0, q}, {28'd0, exp_q});
         if (cmd_ready) acc_seen++;
         if (done) done_seen++;
         @(posedge clk);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_data  = 4'h0;
      check("b2b_accepts", acc_seen, 32'd3);
      check("b2b_dones", done_seen, 32'd3);
      check("b2b_final_q", {28'd0, q}, 32'hE);
      $display("txn b2b accepts=%0d dones=%0d q=%h", acc_seen, done_seen, q);

      // Abort a count of 10 after 3 steps (E -> F,0,1)
      issue(3'd5, 4'h0, 8'd10);
      repeat (4) @(negedge clk);
      check("abort_pre_q", {28'd0, q}, 32'h1);
      check("abort_pre_busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      check("abort_q", {28'd0, q}, 32'd0);
      check("abort_ready", {31'd0, cmd_ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_jk", {24'd0, j_out, k_out}, 32'd0);
      done_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      rst = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("abort_no_done", done_seen, 32'd0);
      check("abort_idle_busy", {31'd0, busy}, 32'd0);
      check("abort_idle_ready", {31'd0, cmd_ready}, 32'd1);
      check("abort_idle_q", {28'd0, q}, 32'd0);
      $display("txn abort q=%h busy=%0d", q, busy);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
